// File: rtl/polara_loopback_pkg.sv
// Polara loopback shared definitions: header layout, expected
// header constants, FSM states and error codes (generator + checker).
package polara_loopback_pkg;

    localparam int CHIPID_LSB  = 50;
    localparam int XPOS_LSB    = 42;
    localparam int YPOS_LSB    = 34;
    localparam int FBITS_LSB   = 30;
    localparam int LEN_LSB     = 22;
    localparam int MSGTYPE_LSB = 14;

    localparam logic [13:0] CHIPID_EXP  = 14'b10000000000000;
    localparam logic [3:0]  FBITS_EXP   = 4'b0010;
    localparam logic [7:0]  MSGTYPE_EXP = 8'd18;
    localparam logic [7:0]  LEN_PLAIN   = 8'd0;
    localparam logic [7:0]  LEN_MARCH   = 8'd65;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_REPORT
    } lb_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_HDR     = 3'd1,
        ERR_LEN     = 3'd2,
        ERR_DATA    = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_SEL     = 3'd5
    } lb_err_t;

    // Well-formed loopback header; MSHR and RSVD left at zero.
    function automatic logic [63:0] make_hdr(input logic [7:0] len,
                                             input logic [7:0] msgtype);
        logic [63:0] h;
        h = '0;
        h[CHIPID_LSB +: 14] = CHIPID_EXP;
        h[FBITS_LSB +: 4]   = FBITS_EXP;
        h[LEN_LSB +: 8]     = len;
        h[MSGTYPE_LSB +: 8] = msgtype;
        return h;
    endfunction

endpackage

// File: rtl/polara_loopback_noc_mux.sv
// Selects data/valid of the chosen NoC and returns ready to it only.
module polara_loopback_noc_mux (
    input  logic [1:0]  sel,
    input  logic [63:0] data1,
    input  logic [63:0] data2,
    input  logic [63:0] data3,
    input  logic        val1,
    input  logic        val2,
    input  logic        val3,
    input  logic        rdy,
    output logic [63:0] data,
    output logic        val,
    output logic        rdy1,
    output logic        rdy2,
    output logic        rdy3
);

    always_comb begin
        data = '0;
        val  = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        rdy3 = 1'b0;
        case (sel)
            2'd1: begin
                data = data1;
                val  = val1;
                rdy1 = rdy;
            end
            2'd2: begin
                data = data2;
                val  = val2;
                rdy2 = rdy;
            end
            2'd3: begin
                data = data3;
                val  = val3;
                rdy3 = rdy;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/polara_loopback_checker.sv
// Receive-side loopback checker: header check, walking-one payload
// check, saturating pass/error counters and sticky error flag.
module polara_loopback_checker
    import polara_loopback_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
    parameter int          CNT_W          = 16
) (
    input  logic             chipset_clk,
    input  logic             chip_rst_n,
    input  logic [1:0]       sw_debounced,
    input  logic             clear,
    input  logic [63:0]      intf_chipset_data_noc1,
    input  logic [63:0]      intf_chipset_data_noc2,
    input  logic [63:0]      intf_chipset_data_noc3,
    input  logic             intf_chipset_val_noc1,
    input  logic             intf_chipset_val_noc2,
    input  logic             intf_chipset_val_noc3,
    output logic             intf_chipset_rdy_noc1,
    output logic             intf_chipset_rdy_noc2,
    output logic             intf_chipset_rdy_noc3,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic [2:0]       last_err,
    output logic             busy
);

    lb_state_t   state_q, state_d;
    lb_err_t     code_q, code_d;
    logic [6:0]  idx_q, idx_d;
    logic [63:0] exp_q, exp_d;
    logic [15:0] gap_q, gap_d;
    logic [1:0]  sw_q;
    logic [63:0] data;
    logic        val;
    logic        rdy;
    logic        xfer;
    logic        hdr_ok;
    logic [7:0]  hdr_len;

    // Gated by reset so ready is low while the chip is held in reset.
    assign rdy  = chip_rst_n && (sw_debounced != 2'd0)
                  && (state_q != ST_REPORT);
    assign xfer = val && rdy;
    assign busy = (state_q == ST_PAYLOAD);

    assign hdr_len = data[LEN_LSB +: 8];
    assign hdr_ok  = (data[CHIPID_LSB +: 14] == CHIPID_EXP)
                     && (data[XPOS_LSB +: 8] == 8'd0)
                     && (data[YPOS_LSB +: 8] == 8'd0)
                     && (data[FBITS_LSB +: 4] == FBITS_EXP)
                     && (data[MSGTYPE_LSB +: 8] == MSGTYPE_EXP);

    polara_loopback_noc_mux u_mux (
        .sel   (sw_debounced),
        .data1 (intf_chipset_data_noc1),
        .data2 (intf_chipset_data_noc2),
        .data3 (intf_chipset_data_noc3),
        .val1  (intf_chipset_val_noc1),
        .val2  (intf_chipset_val_noc2),
        .val3  (intf_chipset_val_noc3),
        .rdy   (rdy),
        .data  (data),
        .val   (val),
        .rdy1  (intf_chipset_rdy_noc1),
        .rdy2  (intf_chipset_rdy_noc2),
        .rdy3  (intf_chipset_rdy_noc3)
    );

    always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= ERR_NONE;
            idx_q   <= '0;
            exp_q   <= '0;
            gap_q   <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            gap_q   <= gap_d;
            sw_q    <= sw_debounced;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                code_d = ERR_NONE;
                gap_d  = '0;
                if (xfer) begin
                    state_d = ST_REPORT;
                    if (!hdr_ok) begin
                        code_d = ERR_HDR;
                    end else if (hdr_len == LEN_MARCH) begin
                        idx_d   = '0;
                        exp_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else if (hdr_len != LEN_PLAIN) begin
                        code_d = ERR_LEN;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A select change aborts and drops that cycle's flit.
                if (sw_debounced != sw_q) begin
                    code_d  = ERR_SEL;
                    state_d = ST_REPORT;
                end else if (xfer) begin
                    gap_d = '0;
                    if (data != exp_q && code_q == ERR_NONE)
                        code_d = ERR_DATA;
                    if (idx_q == 7'd64) begin
                        state_d = ST_REPORT;
                    end else begin
                        idx_d = idx_q + 7'd1;
                        exp_d = (idx_q == 7'd0) ? 64'd1 : exp_q << 1;
                    end
                end else if (gap_q == TIMEOUT_CYCLES - 16'd1) begin
                    code_d  = ERR_TIMEOUT;
                    state_d = ST_REPORT;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            pkt_count  <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
            last_err   <= 3'd0;
        end else if (clear) begin
            pkt_count  <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
            last_err   <= 3'd0;
        end else if (state_q == ST_REPORT) begin
            if (code_q == ERR_NONE) begin
                if (pkt_count != '1)
                    pkt_count <= pkt_count + 1'b1;
            end else begin
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                err_sticky <= 1'b1;
                last_err   <= code_q;
            end
        end
    end

endmodule

// File: doc/polara_loopback_checker.md
Name: polara_loopback_checker

Overview:
- Receive-side stage of the Polara chipset loopback path. Consumes the NoC flits the chip returns after the loopback packet generator has injected them.
- Parses each header and checks the fixed loopback header fields. For march packets, checks the 65-flit walking-one payload.
- Exposes packet and error counters plus a sticky pass/fail flag for LEDs and debug.
- Sits between the chip-to-chipset NoC interface and the FPGA debug outputs. Shares the debounced NoC-select switches with the generator.

Parameters:
- TIMEOUT_CYCLES, 16'd4096: maximum gap between payload flits before a packet is aborted.
- CNT_W, 16: width of the packet and error counters.

Ports:
- chipset_clk  in  1  clock
- chip_rst_n  in  1  asynchronous active-low reset
- sw_debounced  in  2  NoC select: 1 = noc1, 2 = noc2, 3 = noc3, 0 = disabled
- clear  in  1  synchronous clear of counters and sticky flags
- intf_chipset_data_noc1/2/3  in  64 each  flit data from chip
- intf_chipset_val_noc1/2/3  in  1 each  flit valid
- intf_chipset_rdy_noc1/2/3  out  1 each  checker ready
- pkt_count  out  CNT_W  packets received without error
- err_count  out  CNT_W  packets or events flagged in error
- err_sticky  out  1  set on any error, cleared only by reset or clear
- last_err  out  3  code of the most recent error
- busy  out  1  high while in PAYLOAD

Behaviour:
- Reset is decided: chip_rst_n, asynchronous, active-low; clock chipset_clk.
- Reset values: state IDLE, all counters 0, err_sticky 0, last_err 0, busy 0, all rdy 0.
- Header layout, MSB to LSB:
  - CHIPID [63:50], expected 14'b10000000000000
  - XPOS [49:42], expected 0
  - YPOS [41:34], expected 0
  - FBITS [33:30], expected 4'b0010
  - LEN [29:22]
  - MSGTYPE [21:14], expected 8'd18
  - MSHR [13:6], ignored
  - RSVD [5:0], ignored
- Handshake: a flit transfers on the cycle where val & rdy are both high on the selected NoC.
  - rdy is driven only on the selected NoC; the other two are 0.
  - rdy = (sw_debounced != 0) & (state != REPORT).
  - Transfers on unselected NoCs are ignored and never counted.
- FSM: IDLE, PAYLOAD, REPORT.
  - IDLE: on a header transfer, check the fixed fields.
    - Mismatch: error code 1 -> REPORT.
    - LEN == 0: pass -> REPORT.
    - LEN == 65: clear the flit index to 0, load expected = 64'd0 -> PAYLOAD.
    - Any other LEN: error code 2 -> REPORT.
  - PAYLOAD: busy = 1. On each transfer, compare data with expected.
    - The first mismatch latches a packet-fail flag (code 3). Remaining flits are still consumed until 65 total.
    - Expected sequence: index 0 -> 0; index 1 -> 64'd1; thereafter expected <<= 1. Index 64 -> 1<<63.
    - After the transfer at index 64 -> REPORT.
  - REPORT: lasts one cycle with rdy = 0.
    - Pass: pkt_count += 1.
    - Fail: err_count += 1, err_sticky = 1, last_err = code.
    - Then -> IDLE.
- Timeout: in PAYLOAD, a gap counter resets on every transfer. When it reaches TIMEOUT_CYCLES: code 4 -> REPORT.
- Select change: if sw_debounced changes while in PAYLOAD: code 5 -> REPORT. The flit on that same cycle is ignored.
- Counters saturate at all-ones; they do not wrap.
- clear: zeros the counters, err_sticky and last_err.
  - If clear coincides with a REPORT increment, clear wins.
  - clear does not alter the FSM state.
- sw_debounced == 0: FSM held in IDLE. A PAYLOAD in progress aborts via the select-change rule.
- Reset mid-packet returns everything to reset values asynchronously. There is no partial-count carry-over.

Decomposition:
- Shared package/header (polara_loopback_pkg): header field offsets, expected CHIPID/FBITS/MSGTYPE constants, LEN_MARCH = 65, state encodings, error codes 1–5. The generator uses the same package.
- Sub-module polara_loopback_noc_mux: selects the data/val of the chosen NoC and fans rdy back out to it.

Test Plan:
- Plain packet, noc2 (sw = 2): header {CHIPID 0x2000, FBITS 2, LEN 0, TYPE 18}, val held -> rdy2 = 1, rdy1 = rdy3 = 0, pkt_count = 1 two cycles after transfer, err_sticky = 0.
- March packet, noc3 (sw = 3): header LEN 65, then flits 0, 1, 2, …, 1<<63 with random val gaps < 100 -> pkt_count = 1, busy high for the whole payload.
- Corrupted payload: march with flit index 10 = 0x3FF -> err_count = 1, last_err = 3, all 65 flits consumed, next plain packet passes (pkt_count = 1).
- Bad header and length: MSGTYPE 17 -> last_err = 1; LEN 5 -> last_err = 2; err_count = 2.
- Timeout with TIMEOUT_CYCLES = 16: 20 flits then val low -> last_err = 4 after 16 idle cycles, FSM returns to IDLE.
- Select change and clear: switch sw 1 -> 2 mid-payload -> last_err = 5; then pulse clear in the same cycle as a passing REPORT -> counters 0, err_sticky 0.
